record_drain_tx: RTL

Reads the 25-bit records that the receive path deposits into the shared record RAM and sends them off-chip as framed bit-serial words.
- It owns the RAM read port (`read_add`/`rd_en`/`read_data`) and tracks its own read pointer against the receiver's write address.
- It serialises one record per frame: start bit, 25 data bits LSB-first, optional even parity, stop bit.
- It drains continuously while enabled, so the control unit's RAM becomes a 128-deep FIFO between the receive unit and the host link.

---
 rtl/record_drain_tx_pkg.sv | 19 +
 rtl/record_drain_tx_if.sv | 27 ++
 rtl/record_drain_tx_baud_tick.sv | 26 ++
 rtl/record_drain_tx.sv | 103 ++++++++++
 4 files changed

// File: rtl/record_drain_tx_pkg.sv
// Shared types for the record drain transmitter.
// Holds the FSM state enum, record/RAM sizes and the frame length helper.
package ultra_pkg;
  localparam int REC_W  = 25;
  localparam int RAM_AW = 7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SHIFT,
    DONE
  } drain_state_t;

  // start + data + [parity] + stop
  function automatic int frame_len(input bit parity_en);
    return parity_en ? REC_W + 3 : REC_W + 2;
  endfunction
endpackage

// File: rtl/record_drain_tx_if.sv
// Record RAM read port plus the receiver's write address.
// master: drain side (rd_en/read_add out); slave: RAM side.
interface record_drain_tx_if
  import ultra_pkg::*;
#(
  parameter int DW = REC_W,
  parameter int AW = RAM_AW
) ();
  logic          rd_en;
  logic [AW-1:0] read_add;
  logic [DW-1:0] read_data;
  logic [AW-1:0] wr_ptr;

  modport master (
    output rd_en,
    output read_add,
    input  read_data,
    input  wr_ptr
  );

  modport slave (
    input  rd_en,
    input  read_add,
    output read_data,
    output wr_ptr
  );
endinterface

// File: rtl/record_drain_tx_baud_tick.sv
// Bit-period timer: free counter cleared on load_i.
// Ports: clk, rst, load_i (restart period), tick_o (last cycle of a bit).
module baud_tick #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic tick_o
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(BAUD_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (load_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/record_drain_tx.sv
// Drains records from the shared RAM and sends them as serial frames.
// Ports: clk, rst, enable, ram (RAM read port), tx, busy, empty, pending, frame_done.
module record_drain_tx
  import ultra_pkg::*;
#(
  parameter int DATA_W    = REC_W,
  parameter int ADDR_W    = RAM_AW,
  parameter int BAUD_DIV  = 16,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  record_drain_tx_if.master        ram,
  output logic                     tx,
  output logic                     busy,
  output logic                     empty,
  output logic [ADDR_W-1:0]        pending,
  output logic                     frame_done
);
  localparam int FL = frame_len(PARITY_EN);
  localparam int BW = $clog2(FL);

  drain_state_t      state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [FL-1:0]     frame_q, frame_d;
  logic [DATA_W+2:0] fw;
  logic              tick;
  logic              load;

  baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .tick_o (tick)
  );

  // Whole frame, LSB sent first; without parity the top bit drops off.
  always_comb begin
    fw = {1'b1,
          (PARITY_EN ? ^ram.read_data : 1'b1),
          ram.read_data,
          1'b0};
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        frame_d = fw[FL-1:0];
        bit_d   = '0;
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          frame_d = {1'b1, frame_q[FL-1:1]};
          if (bit_q == BW'(FL - 1)) state_d = DONE;
          else bit_d = bit_q + BW'(1);
        end
      end
      DONE: begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      bit_q    <= '0;
      frame_q  <= '1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
    end
  end

  // Outputs decode from registered state, so reset forces them at once.
  assign tx           = (state_q == SHIFT) ? frame_q[0] : 1'b1;
  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);
  assign ram.rd_en    = (state_q == FETCH);
  assign ram.read_add = rd_ptr_q;
  assign empty        = (rd_ptr_q == ram.wr_ptr);
  assign pending      = ram.wr_ptr - rd_ptr_q;
endmodule
